// File: rtl/adc_sample_fifo_ahb.sv
// AHB-Lite slave that unpacks the ADC wrapper's packed 12-bit sample stream into a FIFO,
// drives the wrapper's control inputs from CPU registers and raises a fill-threshold interrupt.
module adc_sample_fifo_ahb #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        hclk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [11:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    input  logic [23:0] adc_din,
    input  logic        adc_drdy,
    output logic        adc_enable,
    output logic        adc_double,
    output logic [15:0] adc_div,
    output logic        irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [11:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d, thresh_q, thresh_d;
    logic                  en_q, en_d, dbl_q, dbl_d;
    logic [15:0]           div_q, div_d;
    logic                  ovf_q, ovf_d, irq_q, irq_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [11:0]           pend_q, pend_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [1:0]            wr_addr_q, wr_addr_d;
    logic [31:0]           hrdata_q, hrdata_d;

    logic        ahb_acc_s, rd_s, ctrl_wr_s, stat_wr_s, thr_wr_s, flush_s;
    logic        empty_s, full_s, pop_s;
    logic        push_req_s, pend_set_s, drop_s, push_s, full_drop_s;
    logic [11:0] push_data_s;
    logic [31:0] status_s;
    logic        unused_s;

    assign unused_s  = &{1'b0, hsize, haddr[11:4], haddr[1:0], hwdata};

    assign ahb_acc_s = hsel & htrans[1] & hready;
    assign rd_s      = ahb_acc_s & ~hwrite;
    assign ctrl_wr_s = wr_pend_q & (wr_addr_q == 2'd0);
    assign stat_wr_s = wr_pend_q & (wr_addr_q == 2'd1);
    assign thr_wr_s  = wr_pend_q & (wr_addr_q == 2'd3);
    // Disabling the ADC path discards everything buffered so a re-enable starts clean.
    assign flush_s   = ctrl_wr_s & en_q & ~hwdata[0];

    assign empty_s   = (count_q == {CW{1'b0}});
    assign full_s    = (count_q == FULL_CNT);
    assign pop_s     = rd_s & (haddr[3:2] == 2'd2) & ~empty_s & ~flush_s;
    assign push_s    = push_req_s & (~full_s | pop_s) & ~flush_s;
    assign full_drop_s = push_req_s & full_s & ~pop_s & ~flush_s;
    assign status_s  = {20'd0, irq_q, ovf_q, full_s, empty_s, {(8-CW){1'b0}}, count_q};

    // Ingest selection: a pending upper half always wins the push slot over a new word.
    always_comb begin
        push_req_s  = 1'b0;
        push_data_s = pend_q;
        pend_set_s  = 1'b0;
        drop_s      = 1'b0;
        if (pend_vld_q) begin
            push_req_s  = 1'b1;
            push_data_s = pend_q;
            drop_s      = adc_drdy & en_q;
        end else if (adc_drdy & en_q) begin
            push_req_s  = 1'b1;
            push_data_s = adc_din[11:0];
            pend_set_s  = dbl_q;
        end else begin
            push_req_s  = 1'b0;
        end
    end

    // Next-state for FIFO bookkeeping, registers and AHB phase tracking.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        en_d       = en_q;
        dbl_d      = dbl_q;
        div_d      = div_q;
        thresh_d   = thresh_q;
        ovf_d      = ovf_q;
        hrdata_d   = hrdata_q;
        wr_pend_d  = ahb_acc_s & hwrite;
        wr_addr_d  = haddr[3:2];
        irq_d      = (thresh_q != {CW{1'b0}}) & ((count_q >= thresh_q) | ovf_q);

        if (flush_s) begin
            wr_ptr_d   = {DEPTH_LOG2{1'b0}};
            rd_ptr_d   = {DEPTH_LOG2{1'b0}};
            count_d    = {CW{1'b0}};
            pend_vld_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (pend_set_s) begin
                pend_vld_d = 1'b1;
                pend_d     = adc_din[23:12];
            end else begin
                pend_vld_d = 1'b0;
            end
        end

        if (stat_wr_s & hwdata[10]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if ((drop_s | full_drop_s) & ~flush_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end

        if (ctrl_wr_s) begin
            en_d  = hwdata[0];
            dbl_d = hwdata[1];
            div_d = hwdata[31:16];
        end else begin
            en_d  = en_q;
        end
        if (thr_wr_s) begin
            thresh_d = hwdata[CW-1:0];
        end else begin
            thresh_d = thresh_q;
        end

        if (rd_s) begin
            case (haddr[3:2])
                2'd0:    hrdata_d = {div_q, 14'd0, dbl_q, en_q};
                2'd1:    hrdata_d = status_s;
                2'd2:    hrdata_d = empty_s ? 32'd0 : {20'd0, mem_q[rd_ptr_q]};
                2'd3:    hrdata_d = {{(32-CW){1'b0}}, thresh_q};
                default: hrdata_d = hrdata_q;
            endcase
        end else begin
            hrdata_d = hrdata_q;
        end
    end

    // Sample storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge hclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    // State registers.
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
            count_q    <= {CW{1'b0}};
            thresh_q   <= {CW{1'b0}};
            pend_vld_q <= 1'b0;
            pend_q     <= 12'd0;
            en_q       <= 1'b0;
            dbl_q      <= 1'b0;
            div_q      <= 16'd0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= 2'd0;
            hrdata_q   <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            thresh_q   <= thresh_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            en_q       <= en_d;
            dbl_q      <= dbl_d;
            div_q      <= div_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            hrdata_q   <= hrdata_d;
        end
    end

    assign hrdata     = hrdata_q;
    assign hreadyout  = 1'b1;
    assign hresp      = 1'b0;
    assign adc_enable = en_q;
    assign adc_double = dbl_q;
    assign adc_div    = div_q;
    assign irq        = irq_q;
endmodule

// File: tb/tb_adc_sample_fifo_ahb.sv
// Scoreboard bench for adc_sample_fifo_ahb: a queue-based FIFO model predicts every read,
// and a monitor compares hrdata in each read data phase.
module tb_adc_sample_fifo_ahb;
    logic        hclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [11:0] haddr = 12'd0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic        hready = 1'b1;
    logic [31:0] hwdata = 32'd0;
    logic [31:0] hrdata;
    logic        hreadyout, hresp;
    logic [23:0] adc_din = 24'd0;
    logic        adc_drdy = 1'b0;
    logic        adc_enable, adc_double, irq;
    logic [15:0] adc_div;

    always #5 hclk = ~hclk;

    adc_sample_fifo_ahb #(.DEPTH_LOG2(6)) dut (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready), .hwdata(hwdata),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
        .adc_din(adc_din), .adc_drdy(adc_drdy), .adc_enable(adc_enable),
        .adc_double(adc_double), .adc_div(adc_div), .irq(irq)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          mq[$];
    bit          m_ovf = 1'b0, m_en = 1'b0, m_dbl = 1'b0;
    int          m_thr = 0;
    logic [15:0] m_div = 16'd0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic void m_push(int v);
        if (mq.size() == 64) m_ovf = 1'b1;
        else mq.push_back(v);
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'd0;
        return mq.pop_front();
    endfunction

    function automatic bit m_irq();
        return (m_thr != 0) && ((mq.size() >= m_thr) || m_ovf);
    endfunction

    function automatic logic [31:0] m_status();
        int c;
        logic [31:0] s;
        c = mq.size();
        s = 32'd0;
        s[6:0] = c[6:0];
        s[8]   = (c == 0);
        s[9]   = (c == 64);
        s[10]  = m_ovf;
        s[11]  = m_irq();
        return s;
    endfunction

    // Monitor: each accepted read address phase is followed by one data phase to check.
    initial begin : monitor
        bit rd_now;
        logic [31:0] e;
        forever begin
            @(posedge hclk);
            rd_now = rst_n && hsel && htrans[1] && hready && !hwrite;
            @(negedge hclk);
            if (rd_now) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL hrdata: read data 0x%0h with no queued expectation", hrdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("hrdata", hrdata, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic ahb_write(logic [3:0] a, logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = {8'd0, a};
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(posedge hclk); #1;
        case (a)
            4'h0: begin
                if (m_en && !d[0]) mq.delete();
                m_en = d[0]; m_dbl = d[1]; m_div = d[31:16];
            end
            4'h4: if (d[10]) m_ovf = 1'b0;
            4'hC: m_thr = int'(d[6:0]);
            default: ;
        endcase
    endtask

    task automatic ahb_read(logic [3:0] a);
        logic [31:0] e;
        idle(2);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = {8'd0, a};
        case (a)
            4'h0:    e = {m_div, 14'd0, m_dbl, m_en};
            4'h4:    e = m_status();
            4'h8:    e = m_pop();
            default: e = m_thr;
        endcase
        exp_q.push_back(e);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic adc_pulse(logic [23:0] d);
        adc_din = d; adc_drdy = 1'b1;
        @(posedge hclk); #1;
        adc_drdy = 1'b0;
        @(posedge hclk); #1;
        if (m_en) begin
            m_push(int'(d[11:0]));
            if (m_dbl) m_push(int'(d[23:12]));
        end
    endtask

    // Two back-to-back words: in double mode the second collides with the pending half.
    task automatic adc_burst2(logic [23:0] d1, logic [23:0] d2);
        adc_din = d1; adc_drdy = 1'b1;
        @(posedge hclk); #1;
        adc_din = d2;
        @(posedge hclk); #1;
        adc_drdy = 1'b0;
        idle(1);
        if (m_en) begin
            m_push(int'(d1[11:0]));
            if (m_dbl) begin
                m_push(int'(d1[23:12]));
                m_ovf = 1'b1;
            end else begin
                m_push(int'(d2[11:0]));
            end
        end
    endtask

    task automatic read_with_drdy(logic [23:0] d);
        idle(2);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 12'h008;
        adc_din = d; adc_drdy = 1'b1;
        exp_q.push_back(m_pop());
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; adc_drdy = 1'b0;
        idle(1);
        if (m_en) begin
            m_push(int'(d[11:0]));
            if (m_dbl) m_push(int'(d[23:12]));
        end
    endtask

    initial begin : stim
        int r;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_hreadyout", hreadyout, 32'd1);
        chk("rst_hresp", hresp, 32'd0);
        chk("rst_adc_enable", adc_enable, 32'd0);
        chk("rst_adc_double", adc_double, 32'd0);
        chk("rst_adc_div", adc_div, 32'd0);
        chk("rst_irq", irq, 32'd0);
        rst_n = 1'b1;
        idle(1);
        ahb_read(4'h4);
        ahb_read(4'h0);
        ahb_read(4'hC);

        // Double-mode unpacking
        ahb_write(4'h0, 32'h0063_0003);
        chk("adc_enable", adc_enable, 32'd1);
        chk("adc_double", adc_double, 32'd1);
        chk("adc_div", adc_div, 32'h63);
        adc_pulse(24'hABC123);
        adc_pulse(24'h456789);
        ahb_read(4'h4);
        repeat (4) ahb_read(4'h8);
        ahb_read(4'h4);

        // Fill to full, overflow, drain, W1C
        ahb_write(4'h0, 32'h0);
        ahb_write(4'h0, 32'h1);
        for (int i = 0; i < 64; i++) adc_pulse(24'(i));
        adc_pulse(24'h000040);
        ahb_read(4'h4);
        repeat (64) ahb_read(4'h8);
        ahb_write(4'h4, 32'h400);
        ahb_read(4'h4);

        // Full FIFO with a simultaneous pop and push
        for (int i = 0; i < 64; i++) adc_pulse(24'(12'h100 + i));
        read_with_drdy(24'h0000FF);
        ahb_read(4'h4);
        repeat (64) ahb_read(4'h8);
        ahb_read(4'h4);

        // Threshold interrupt with one-cycle latency
        ahb_write(4'hC, 32'd3);
        adc_pulse(24'd1);
        adc_pulse(24'd2);
        idle(1);
        chk("irq_below_thresh", irq, 32'(m_irq()));
        adc_din = 24'd3; adc_drdy = 1'b1;
        @(posedge hclk); #1;
        adc_drdy = 1'b0;
        m_push(3);
        chk("irq_latency", irq, 32'd0);
        @(posedge hclk); #1;
        chk("irq_at_thresh", irq, 32'(m_irq()));
        ahb_read(4'h8);
        idle(1);
        chk("irq_after_pop", irq, 32'(m_irq()));
        repeat (2) ahb_read(4'h8);

        // Empty read, then flush with overflow set
        ahb_read(4'h8);
        ahb_read(4'h4);
        ahb_write(4'h0, 32'h3);
        adc_burst2(24'h111222, 24'h333444);
        for (int i = 0; i < 4; i++) adc_pulse(24'(i * 24'h001001 + 24'h010020));
        ahb_read(4'h4);
        ahb_write(4'h0, 32'h2);
        ahb_read(4'h4);
        idle(1);
        chk("irq_flush_ovf", irq, 32'(m_irq()));

        // Randomised traffic
        ahb_write(4'h4, 32'h400);
        ahb_write(4'h0, 32'h1);
        for (int k = 0; k < 300; k++) begin
            r = $urandom();
            case ($urandom_range(0, 7))
                0, 1, 2: adc_pulse(24'(r));
                3:       ahb_read(4'h8);
                4:       ahb_read(4'h4);
                5:       ahb_write(4'h0, {r[15:0], 14'd0, r[16], (r[19:17] != 3'd0)});
                6:       if (r[20]) ahb_write(4'hC, 32'($urandom_range(0, 64)));
                         else adc_burst2(24'(r), 24'($urandom()));
                default: if (r[21]) read_with_drdy(24'(r));
                         else ahb_write(4'h4, {21'd0, r[22], 10'd0});
            endcase
            if (k % 10 == 0) begin
                idle(1);
                chk("rand_irq", irq, 32'(m_irq()));
                chk("rand_adc_enable", adc_enable, 32'(m_en));
            end
        end

        // Reset during a CTRL write data phase
        ahb_write(4'h0, 32'h1);
        ahb_write(4'hC, 32'd1);
        adc_pulse(24'd5);
        idle(1);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 12'h000;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h3;
        rst_n = 1'b0;
        #2;
        chk("async_rst_enable", adc_enable, 32'd0);
        chk("async_rst_irq", irq, 32'd0);
        @(posedge hclk); #1;
        rst_n = 1'b1;
        mq.delete(); m_ovf = 1'b0; m_en = 1'b0; m_dbl = 1'b0; m_div = 16'd0; m_thr = 0;
        idle(1);
        chk("post_rst_enable", adc_enable, 32'd0);
        chk("post_rst_irq", irq, 32'd0);
        ahb_read(4'h0);
        ahb_read(4'h4);
        ahb_read(4'h8);

        idle(3);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
